// File: rtl/flow_rr_arbiter_pkg.sv
// Shared types and helpers for the flow round-robin arbiter slice.
package flow_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_BW = 4;
    localparam int unsigned DEF_CW = 16;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flow_rr_arbiter_pick.sv
// Rotating-priority encoder: first set req scanning from ptr upward, wrapping mod NSRC.
module flow_rr_pick
    import flow_arb_pkg::*;
#(
    parameter  int unsigned NSRC = 2,
    localparam int unsigned IDW  = id_width(NSRC)
) (
    input  logic [NSRC-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  idx
);

    int unsigned j;

    always_comb begin
        any = 1'b0;
        idx = '0;
        j   = 0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            j = int'(ptr) + k;
            if (j >= NSRC) j = j - NSRC;
            if (!any && req[j]) begin
                any = 1'b1;
                idx = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/flow_rr_arbiter.sv
// Round-robin valid/ready arbiter with burst-limited grant hold in front of a flow converter.
module flow_rr_arbiter
    import flow_arb_pkg::*;
#(
    parameter  int unsigned NSRC   = 2,
    parameter  int unsigned DWIDTH = 8,
    parameter  int unsigned BW     = DEF_BW,
    parameter  int unsigned CW     = DEF_CW,
    localparam int unsigned IDW    = id_width(NSRC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_en,
    input  logic [BW-1:0]          cfg_burst,
    input  logic [NSRC-1:0]        src_val,
    output logic [NSRC-1:0]        src_rdy,
    input  logic [NSRC*DWIDTH-1:0] src_data,
    output logic                   dst_val,
    input  logic                   dst_rdy,
    output logic [DWIDTH-1:0]      dst_data,
    output logic [IDW-1:0]         dst_id,
    output logic [NSRC*CW-1:0]     xfer_cnt
);

    arb_state_e                   state_q, state_d;
    logic [IDW-1:0]               gnt_q, gnt_d;
    logic [IDW-1:0]               ptr_q, ptr_d;
    logic [BW-1:0]                beat_q, beat_d;
    logic [BW-1:0]                lim_q, lim_d;
    logic [NSRC-1:0][CW-1:0]      cnt_q, cnt_d;
    logic [NSRC-1:0][DWIDTH-1:0]  data_arr;
    logic                         pick_any;
    logic [IDW-1:0]               pick_idx;
    logic                         xfer;
    logic                         last_beat;

    assign data_arr = src_data;
    assign xfer_cnt = cnt_q;

    flow_rr_pick #(
        .NSRC (NSRC)
    ) u_pick (
        .req (src_val),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        beat_d    = beat_q;
        lim_d     = lim_q;
        cnt_d     = cnt_q;
        dst_val   = 1'b0;
        src_rdy   = '0;
        dst_data  = '0;
        dst_id    = '0;
        xfer      = 1'b0;
        last_beat = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_en && pick_any) begin
                    state_d = BUSY;
                    gnt_d   = pick_idx;
                    lim_d   = cfg_burst;
                    beat_d  = '0;
                end
            end
            BUSY: begin
                dst_id   = gnt_q;
                dst_data = data_arr[gnt_q];
                // Disable kills the handshake in the same cycle so no beat slips through.
                if (cfg_en) begin
                    dst_val        = src_val[gnt_q];
                    src_rdy[gnt_q] = dst_rdy;
                end
                xfer      = dst_val && dst_rdy;
                last_beat = (lim_q != '0) && (beat_q == lim_q - 1'b1);
                if (xfer) begin
                    cnt_d[gnt_q] = cnt_q[gnt_q] + 1'b1;
                    if (beat_q != '1) beat_d = beat_q + 1'b1;
                end
                if (!cfg_en || !src_val[gnt_q] || (xfer && last_beat)) begin
                    state_d = IDLE;
                    ptr_d   = (gnt_q == IDW'(NSRC - 1)) ? '0 : gnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            lim_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            lim_q   <= lim_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_flow_rr_arbiter.sv
// Randomised + directed bench for flow_rr_arbiter against a grant-ownership reference model.
module tb_flow_rr_arbiter;

    localparam int NSRC = 2;
    localparam int DW   = 8;
    localparam int BW   = 4;
    localparam int CW   = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_en;
    logic [BW-1:0]        cfg_burst;
    logic [NSRC-1:0]      src_val;
    logic [NSRC-1:0]      src_rdy;
    logic [NSRC*DW-1:0]   src_data;
    logic                 dst_val;
    logic                 dst_rdy;
    logic [DW-1:0]        dst_data;
    logic [0:0]           dst_id;
    logic [NSRC*CW-1:0]   xfer_cnt;

    always #5 clk = ~clk;

    flow_rr_arbiter #(
        .NSRC   (NSRC),
        .DWIDTH (DW),
        .BW     (BW),
        .CW     (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_en    (cfg_en),
        .cfg_burst (cfg_burst),
        .src_val   (src_val),
        .src_rdy   (src_rdy),
        .src_data  (src_data),
        .dst_val   (dst_val),
        .dst_rdy   (dst_rdy),
        .dst_data  (dst_data),
        .dst_id    (dst_id),
        .xfer_cnt  (xfer_cnt)
    );

    int errs   = 0;
    int checks = 0;
    bit live   = 1'b0;

    // Reference model: who owns the channel (-1 = nobody), where the scan starts,
    // beats taken in this grant, the grant's limit, and per-source totals mod 2^CW.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_beats = 0;
    int m_lim   = 0;
    int m_cnt [NSRC];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int  o;
        bit  take;
        bit  done;
        bit  found;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_beats = 0;
            m_lim   = 0;
            for (int i = 0; i < NSRC; i++) m_cnt[i] = 0;
        end else if (m_owner < 0) begin
            if (cfg_en && src_val != '0) begin
                found = 1'b0;
                for (int k = 0; k < NSRC; k++) begin
                    if (!found && src_val[(m_ptr + k) % NSRC]) begin
                        found   = 1'b1;
                        m_owner = (m_ptr + k) % NSRC;
                    end
                end
                m_lim   = int'(cfg_burst);
                m_beats = 0;
            end
        end else begin
            o    = m_owner;
            take = cfg_en && src_val[o] && dst_rdy;
            if (take) begin
                m_cnt[o] = (m_cnt[o] + 1) % (1 << CW);
                m_beats++;
            end
            done = !cfg_en || !src_val[o] || (take && m_lim != 0 && m_beats == m_lim);
            if (done) begin
                m_owner = -1;
                m_ptr   = (o + 1) % NSRC;
            end
        end
    end

    always @(negedge clk) begin
        logic            ev;
        logic [NSRC-1:0] er;
        if (live) begin
            ev = 1'b0;
            er = '0;
            if (m_owner >= 0 && cfg_en) begin
                ev          = src_val[m_owner];
                er[m_owner] = dst_rdy;
            end
            chk("dst_val", 64'(dst_val), 64'(ev));
            chk("src_rdy", 64'(src_rdy), 64'(er));
            chk("dst_id",  64'(dst_id), (m_owner >= 0) ? 64'(m_owner) : 64'd0);
            if (ev)
                chk("dst_data", 64'(dst_data), 64'(src_data[m_owner*DW +: DW]));
            else if (m_owner < 0)
                chk("dst_data_idle", 64'(dst_data), 64'd0);
            for (int i = 0; i < NSRC; i++)
                chk("xfer_cnt", 64'(xfer_cnt[i*CW +: CW]), 64'(m_cnt[i]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        src_data = (NSRC*DW)'($urandom);
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        logic [CW-1:0] d;
        rst       = 1'b1;
        cfg_en    = 1'b1;
        cfg_burst = 4'd4;
        src_val   = 2'b11;
        dst_rdy   = 1'b1;
        src_data  = '0;

        // Reset held three cycles with both requesters asking.
        cyc();
        live = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_dst_val", 64'(dst_val), 64'd0);
        chk("rst_src_rdy", 64'(src_rdy), 64'd0);
        chk("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("first_idle", 64'(dst_val), 64'd0);
        @(negedge clk);
        chk("first_val", 64'(dst_val), 64'd1);
        chk("first_id", 64'(dst_id), 64'd0);

        // Round-robin, burst 4, continuous traffic.
        repeat (38) cyc();
        @(negedge clk);
        d = xfer_cnt[0 +: CW] - xfer_cnt[CW +: CW];
        chk("rr_balance", 64'(d <= 4 || d >= 12), 64'd1);

        // Backpressure with burst 2.
        cfg_burst = 4'd2;
        for (int i = 0; i < 24; i++) begin
            dst_rdy = (i % 2 == 0);
            cyc();
        end
        dst_rdy = 1'b1;

        // Source drop during an unlimited burst.
        rst_pulse();
        cfg_burst = 4'd0;
        src_val   = 2'b11;
        repeat (4) cyc();
        src_val = 2'b10;
        repeat (6) cyc();
        @(negedge clk);
        chk("drop_cnt0", 64'(xfer_cnt[0 +: CW]), 64'd3);
        chk("drop_id", 64'(dst_id), 64'd1);

        // Disable mid-burst, then resume at the next requester.
        rst_pulse();
        cfg_burst = 4'd8;
        src_val   = 2'b11;
        repeat (3) cyc();
        cfg_en = 1'b0;
        @(negedge clk);
        chk("dis_val", 64'(dst_val), 64'd0);
        chk("dis_rdy", 64'(src_rdy), 64'd0);
        repeat (2) cyc();
        cfg_en = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        chk("dis_cnt0", 64'(xfer_cnt[0 +: CW]), 64'd2);
        chk("resume_id", 64'(dst_id), 64'd1);

        // Counter wrap: 17 beats from requester 1.
        rst_pulse();
        cfg_burst = 4'd0;
        src_val   = 2'b10;
        repeat (18) cyc();
        src_val = 2'b00;
        repeat (2) cyc();
        @(negedge clk);
        chk("wrap_cnt1", 64'(xfer_cnt[CW +: CW]), 64'd1);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            cfg_en    = ($urandom_range(0, 9) != 0);
            dst_rdy   = ($urandom_range(0, 9) < 7);
            cfg_burst = ($urandom_range(0, 3) == 0) ? 4'd0 : BW'($urandom_range(1, 5));
            for (int s = 0; s < NSRC; s++) src_val[s] = ($urandom_range(0, 3) != 0);
            cyc();
        end
        rst = 1'b0;
        cyc();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/flow_rr_arbiter.md
Name: flow_rr_arbiter

Overview:
- Shares one flow converter input (flow_8to16 or flow_16to8 `src_*` side) between NSRC valid/ready requesters.
- Round-robin arbitration with burst-length grant hold; muxes the selected requester onto a single dst valid/ready channel.
- Sits between master_vldrdy instances and the converter; also provides per-source transfer counters for the bench.

Parameters:
- NSRC, 2, number of requesters (2..8).
- DWIDTH, 8, data width per requester (8 in front of flow_8to16, 16 in front of flow_16to8).
- BW, 4, width of cfg_burst.
- CW, 16, width of each per-source transfer counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cfg_en  in  1  enable, active high; valid/ready protocol may be violated on disable.
- cfg_burst  in  BW  max beats per grant; 0 = unlimited; sampled at grant.
- src_val  in  NSRC  valid per requester.
- src_rdy  out  NSRC  ready per requester.
- src_data  in  NSRC*DWIDTH  packed data; requester i at [i*DWIDTH +: DWIDTH].
- dst_val  out  1  valid to converter.
- dst_rdy  in  1  ready from converter.
- dst_data  out  DWIDTH  data of granted requester.
- dst_id  out  $clog2(NSRC)  index of granted requester (0 when idle).
- xfer_cnt  out  NSRC*CW  per-source accepted-beat counters, wrap at 2^CW.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, gnt=0, rr_ptr=0, beat_cnt=0, burst_lim=0, xfer_cnt all 0. Outputs dst_val=0, src_rdy=0, dst_data=0, dst_id=0.
- States: IDLE, BUSY.
- IDLE: dst_val=0, src_rdy=0.
  - If cfg_en && |src_val: pick first set src_val scanning rr_ptr, rr_ptr+1, ... mod NSRC. Register gnt, burst_lim=cfg_burst, beat_cnt=0, then go to BUSY.
  - Latency: request present in IDLE cycle N means dst_val may be 1 in cycle N+1.
- BUSY (combinational mux, no added latency):
  - dst_val=src_val[gnt], dst_data=src_data[gnt], src_rdy[gnt]=dst_rdy, all other src_rdy=0, dst_id=gnt.
  - Transfer = dst_val && dst_rdy: beat_cnt++, xfer_cnt[gnt]++.
- Release BUSY->IDLE (rr_ptr = gnt+1 mod NSRC) on any of:
  - transfer with burst_lim!=0 and beat_cnt==burst_lim-1;
  - src_val[gnt]==0 in any BUSY cycle (no transfer that cycle);
  - cfg_en==0.
- One mandatory IDLE bubble between consecutive grants, even to a different requester.
- Unlimited burst (burst_lim=0): beat_cnt saturates at 2^BW-1; release only by src_val drop or cfg_en.
- cfg_en low in BUSY: immediate IDLE next cycle, dst_val and src_rdy forced 0 that same cycle. In-flight beat not transferred; counters unchanged.
- cfg_burst changes mid-grant: no effect until next grant.
- Only one requester valid: it is re-granted after each bubble regardless of rr_ptr.
- xfer_cnt wraps 2^CW-1 -> 0 silently.
- Sync reset mid-burst: all state cleared next edge; no transfer counted in the reset cycle.

Decomposition:
- Package flow_arb_pkg:
  - state enum {IDLE, BUSY};
  - function clog2-based ID width;
  - constant default BW/CW.
- Sub-module flow_rr_pick (combinational rotating-priority encoder): inputs req[NSRC], ptr; outputs any, idx. Arbiter instantiates it once.

Test Plan:
- Reset/idle: rst=1 for 3 cycles with src_val=2'b11 -> dst_val=0, src_rdy=0, xfer_cnt=0; first dst_val exactly 2 cycles after rst falls (IDLE then BUSY).
- Round-robin, cfg_burst=4, both valid continuously, dst_rdy=1:
  - dst_id sequence: 0 for 4 beats, bubble, 1 for 4 beats, bubble, 0...;
  - after 40 cycles xfer_cnt equal within 4.
- Backpressure, cfg_burst=2, dst_rdy toggling 1010: release only after 2 accepted beats; dst_data stable while dst_val && !dst_rdy; vld_rdy_checker clean.
- Source drop, cfg_burst=0, src0 sends 3 beats then src_val[0]=0: grant released next cycle; src1 granted after one bubble; xfer_cnt[0]=3.
- Disable mid-burst: cfg_en=0 after beat 2 of cfg_burst=8 -> dst_val=0 same cycle, IDLE next; xfer_cnt holds; re-enable resumes from rr_ptr=gnt+1.
- Counter wrap (CW=4): 17 accepted beats from src1 -> xfer_cnt[1]=1.
